// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point multiplier normalise/round/pack stage.
package fp_pkg;

    localparam int          BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        EXC_NORMAL = 3'b000,
        EXC_ZERO   = 3'b001,
        EXC_NAN    = 3'b011,
        EXC_INF    = 3'b100
    } exc_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_PACK,
        S_DONE
    } state_e;

endpackage

// File: rtl/fp_mul_normround_if.sv
// Request/result bundle between the multiplier front end (master) and the normalise/round stage (slave).
interface fp_mul_normround_if;
    import fp_pkg::*;

    logic        Data_valid;
    logic        Sign_in;
    logic [8:0]  Exp_in;
    logic [47:0] Mant_in;
    logic [2:0]  Special_in;
    logic [31:0] Dataout;
    logic        Dataout_valid;
    exc_e        Exc;
    logic        Busy;

    modport master (
        output Data_valid, Sign_in, Exp_in, Mant_in, Special_in,
        input  Dataout, Dataout_valid, Exc, Busy
    );

    modport slave (
        input  Data_valid, Sign_in, Exp_in, Mant_in, Special_in,
        output Dataout, Dataout_valid, Exc, Busy
    );

endinterface

// File: rtl/fp_rne_rounder.sv
// Combinational round-to-nearest-even on a 24-bit significand with guard and sticky bits.
module fp_rne_rounder (
    input  logic [23:0] kept,
    input  logic        guard,
    input  logic        sticky,
    output logic [23:0] rounded,
    output logic        carry
);

    logic        inc;
    logic [24:0] sum;

    // Ties (guard set, sticky clear) only round up when that makes the result even.
    assign inc     = guard & (sticky | kept[0]);
    assign sum     = {1'b0, kept} + {24'd0, inc};
    assign rounded = sum[23:0];
    assign carry   = sum[24];

endmodule

// File: rtl/fp_mul_normround.sv
// Normalise, round and pack a raw 24x24 significand product into IEEE-754 single, fixed 4-edge latency.
module fp_mul_normround #(
    parameter int BIAS = fp_pkg::BIAS
) (
    input logic               CLK,
    input logic               RSTn,
    fp_mul_normround_if.slave bus
);
    import fp_pkg::*;

    state_e             state, next_state;
    logic               sign_q;
    logic [8:0]         exp_q;
    logic [47:0]        mant_q;
    logic [2:0]         special_q;
    logic [23:0]        kept_q;
    logic               guard_q, sticky_q;
    logic signed [9:0]  e_q;
    logic [31:0]        dataout_q;
    exc_e               exc_q;
    logic               valid_q;

    logic [23:0]        rounded;
    logic               carry;
    logic [23:0]        norm_kept;
    logic               norm_guard, norm_sticky;
    logic signed [9:0]  norm_e, e_base;
    logic [31:0]        pack_word;
    exc_e               pack_exc;

    fp_rne_rounder u_rounder (
        .kept    (kept_q),
        .guard   (guard_q),
        .sticky  (sticky_q),
        .rounded (rounded),
        .carry   (carry)
    );

    // Product lies in [1,4): bit 47 set means the binary point moves one place left.
    always_comb begin
        e_base      = $signed({1'b0, exp_q}) - 10'(BIAS);
        norm_kept   = mant_q[46:23];
        norm_guard  = mant_q[22];
        norm_sticky = |mant_q[21:0];
        norm_e      = e_base;
        if (mant_q[47]) begin
            norm_kept   = mant_q[47:24];
            norm_guard  = mant_q[23];
            norm_sticky = |mant_q[22:0];
            norm_e      = e_base + 10'sd1;
        end
    end

    always_comb begin
        pack_word = {sign_q, e_q[7:0], kept_q[22:0]};
        pack_exc  = EXC_NORMAL;
        if (special_q == EXC_ZERO) begin
            pack_word = {sign_q, 31'h0};
            pack_exc  = EXC_ZERO;
        end else if (special_q == EXC_NAN) begin
            pack_word = QNAN;
            pack_exc  = EXC_NAN;
        end else if (special_q == EXC_INF) begin
            pack_word = {sign_q, 8'hFF, 23'h0};
            pack_exc  = EXC_INF;
        end else if (mant_q == 48'd0) begin
            pack_word = {sign_q, 31'h0};
            pack_exc  = EXC_ZERO;
        end else if (e_q >= 10'sd255) begin
            pack_word = {sign_q, 8'hFF, 23'h0};
            pack_exc  = EXC_INF;
        end else if (e_q <= 10'sd0) begin
            pack_word = {sign_q, 31'h0};
            pack_exc  = EXC_ZERO;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (bus.Data_valid) next_state = S_NORM;
            S_NORM:  next_state = S_ROUND;
            S_ROUND: next_state = S_PACK;
            S_PACK:  next_state = S_DONE;
            S_DONE:  if (valid_q && !bus.Data_valid) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Dataout/Exc land on entry to DONE; valid follows one edge later so the result is stable first.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sign_q    <= 1'b0;
            exp_q     <= 9'd0;
            mant_q    <= 48'd0;
            special_q <= 3'd0;
            kept_q    <= 24'd0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            e_q       <= 10'sd0;
            dataout_q <= 32'd0;
            exc_q     <= EXC_NORMAL;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.Data_valid) begin
                        sign_q    <= bus.Sign_in;
                        exp_q     <= bus.Exp_in;
                        mant_q    <= bus.Mant_in;
                        special_q <= bus.Special_in;
                    end
                end
                S_NORM: begin
                    kept_q   <= norm_kept;
                    guard_q  <= norm_guard;
                    sticky_q <= norm_sticky;
                    e_q      <= norm_e;
                end
                S_ROUND: begin
                    if (carry) begin
                        kept_q <= 24'h800000;
                        e_q    <= e_q + 10'sd1;
                    end else begin
                        kept_q <= rounded;
                    end
                end
                S_PACK: begin
                    dataout_q <= pack_word;
                    exc_q     <= pack_exc;
                end
                S_DONE: begin
                    if (!valid_q)              valid_q <= 1'b1;
                    else if (!bus.Data_valid)  valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.Dataout       = dataout_q;
    assign bus.Exc           = exc_q;
    assign bus.Dataout_valid = valid_q;
    assign bus.Busy          = (state != S_IDLE);

endmodule

// File: tb/tb_fp_mul_normround.sv
// Scoreboard bench for fp_mul_normround: directed results from hand-worked IEEE-754 values.
module tb_fp_mul_normround;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  exc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    exp_t sb[$];

    fp_mul_normround_if bus ();

    fp_mul_normround #(.BIAS(127)) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic s, input logic [8:0] e, input logic [47:0] m, input logic [2:0] sp);
        bus.Sign_in    = s;
        bus.Exp_in     = e;
        bus.Mant_in    = m;
        bus.Special_in = sp;
        bus.Data_valid = 1'b1;
    endtask

    // edges counts the capture edge as 1, so a result four edges after capture shows up at edges == 5.
    task automatic run_op(input logic s, input logic [8:0] e, input logic [47:0] m, input logic [2:0] sp,
                          input logic [31:0] xd, input logic [2:0] xe, input string name, input int hold);
        exp_t got;
        int   edges;
        bit   seen;
        sb.push_back('{xd, xe});
        drive(s, e, m, sp);
        edges = 0;
        seen  = 0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.Dataout_valid === 1'b1) seen = 1;
        end
        tests_run++;
        if (!seen) begin
            $display("[TB] FAIL %s timeout: no Dataout_valid within %0d edges", name, edges);
            tests_failed++;
            void'(sb.pop_front());
            bus.Data_valid = 1'b0;
            repeat (4) @(negedge clk);
            return;
        end
        if (edges != 5) begin
            $display("[TB] FAIL %s latency: got %0d edges, want 5", name, edges);
            tests_failed++;
        end
        got = sb.pop_front();
        tests_run++;
        if (bus.Dataout !== got.data) begin
            $display("[TB] FAIL %s data: got %08h, want %08h", name, bus.Dataout, got.data);
            tests_failed++;
        end
        tests_run++;
        if (bus.Exc !== got.exc) begin
            $display("[TB] FAIL %s exc: got %03b, want %03b", name, bus.Exc, got.exc);
            tests_failed++;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (bus.Dataout_valid !== 1'b1 || bus.Dataout !== got.data) begin
                $display("[TB] FAIL %s hold%0d: got valid=%b data=%08h, want valid=1 data=%08h",
                         name, i, bus.Dataout_valid, bus.Dataout, got.data);
                tests_failed++;
            end
        end
        bus.Data_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.Dataout_valid !== 1'b0 || bus.Busy !== 1'b0) begin
            $display("[TB] FAIL %s release: got valid=%b busy=%b, want 0 0", name, bus.Dataout_valid, bus.Busy);
            tests_failed++;
        end
    endtask

    task automatic test_reset;
        rst_n          = 1'b0;
        bus.Data_valid = 1'b0;
        drive(1'b0, 9'd0, 48'd0, 3'd0);
        bus.Data_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.Dataout !== 32'd0 || bus.Exc !== 3'd0 || bus.Dataout_valid !== 1'b0 || bus.Busy !== 1'b0) begin
            $display("[TB] FAIL reset: got data=%08h exc=%03b valid=%b busy=%b, want all 0",
                     bus.Dataout, bus.Exc, bus.Dataout_valid, bus.Busy);
            tests_failed++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_arith;
        run_op(1'b0, 9'd257, 48'h7900_0000_0000, 3'b000, 32'h41720000, 3'b000, "pos_15p125", 0);
        run_op(1'b1, 9'd257, 48'h7900_0000_0000, 3'b000, 32'hC1720000, 3'b000, "neg_15p125", 0);
        run_op(1'b0, 9'd254, 48'h9000_0000_0000, 3'b000, 32'h40100000, 3'b000, "bit47_2p25", 0);
    endtask

    task automatic test_rounding;
        run_op(1'b0, 9'd254, 48'h4000_00C0_0000, 3'b000, 32'h3F800002, 3'b000, "tie_odd_up", 0);
        run_op(1'b0, 9'd254, 48'h4000_0040_0000, 3'b000, 32'h3F800000, 3'b000, "tie_even", 0);
        run_op(1'b0, 9'd254, 48'h7FFF_FFC0_0000, 3'b000, 32'h40000000, 3'b000, "carry_out", 0);
    endtask

    task automatic test_special;
        run_op(1'b0, 9'd400, 48'h4000_0000_0000, 3'b000, 32'h7F800000, 3'b100, "overflow", 0);
        run_op(1'b0, 9'd100, 48'h4000_0000_0000, 3'b000, 32'h00000000, 3'b001, "underflow", 0);
        run_op(1'b0, 9'd254, 48'h4000_0000_0000, 3'b011, 32'h7FC00000, 3'b011, "nan", 0);
        run_op(1'b1, 9'd254, 48'h4000_0000_0000, 3'b100, 32'hFF800000, 3'b100, "inf_special", 0);
        run_op(1'b1, 9'd254, 48'h4000_0000_0000, 3'b001, 32'h80000000, 3'b001, "zero_special", 0);
        run_op(1'b1, 9'd254, 48'h0000_0000_0000, 3'b000, 32'h80000000, 3'b001, "zero_mant", 0);
        run_op(1'b0, 9'd254, 48'h4000_0000_0000, 3'b010, 32'h3F800000, 3'b000, "other_code", 0);
    endtask

    task automatic test_handshake_hold;
        run_op(1'b0, 9'd254, 48'h9000_0000_0000, 3'b000, 32'h40100000, 3'b000, "hold3", 3);
    endtask

    task automatic test_back_to_back;
        run_op(1'b0, 9'd257, 48'h7900_0000_0000, 3'b000, 32'h41720000, 3'b000, "b2b_a", 0);
        run_op(1'b1, 9'd254, 48'h4000_00C0_0000, 3'b000, 32'hBF800002, 3'b000, "b2b_b", 0);
    endtask

    task automatic test_input_ignore;
        exp_t got;
        int   edges;
        bit   seen;
        sb.push_back('{32'h41720000, 3'b000});
        drive(1'b0, 9'd257, 48'h7900_0000_0000, 3'b000);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.Data_valid = 1'b0;
        bus.Sign_in    = 1'b1;
        bus.Exp_in     = 9'($urandom_range(0, 508));
        bus.Mant_in    = {16'($urandom), 32'($urandom)};
        bus.Special_in = 3'b011;
        seen = 0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.Dataout_valid === 1'b1) seen = 1;
        end
        got = sb.pop_front();
        tests_run++;
        if (!seen || edges != 5 || bus.Dataout !== got.data || bus.Exc !== got.exc) begin
            $display("[TB] FAIL ignore: got seen=%b edges=%0d data=%08h exc=%03b, want 1 5 %08h %03b",
                     seen, edges, bus.Dataout, bus.Exc, got.data, got.exc);
            tests_failed++;
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.Dataout_valid !== 1'b0 || bus.Busy !== 1'b0) begin
            $display("[TB] FAIL ignore_release: got valid=%b busy=%b, want 0 0", bus.Dataout_valid, bus.Busy);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid;
        bit stray;
        drive(1'b0, 9'd254, 48'h9000_0000_0000, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.Dataout !== 32'd0 || bus.Exc !== 3'd0 || bus.Dataout_valid !== 1'b0 || bus.Busy !== 1'b0) begin
            $display("[TB] FAIL reset_mid: got data=%08h exc=%03b valid=%b busy=%b, want all 0",
                     bus.Dataout, bus.Exc, bus.Dataout_valid, bus.Busy);
            tests_failed++;
        end
        bus.Data_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.Dataout_valid !== 1'b0) stray = 1;
        end
        tests_run++;
        if (stray) begin
            $display("[TB] FAIL reset_abandon: got a Dataout_valid after reset, want none");
            tests_failed++;
        end
        run_op(1'b1, 9'd257, 48'h7900_0000_0000, 3'b000, 32'hC1720000, 3'b000, "after_reset", 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset;
        test_arith;
        test_rounding;
        test_special;
        test_handshake_hold;
        test_back_to_back;
        test_input_ignore;
        test_reset_mid;
        tests_run++;
        if (sb.size() != 0) begin
            $display("[TB] FAIL scoreboard: got %0d leftover entries, want 0", sb.size());
            tests_failed++;
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
